// File: rtl/sa_ctrl_pkg.sv
// rtl/sa_ctrl_pkg.sv - shared types and defaults for the systolic array sequencer
// Purpose: FSM state encoding, default dimensions, address width and the
//          row/col-to-index helper used by the controller, its interfaces and
//          the operand buffer.
// Ports:   none (package).
package sa_ctrl_pkg;

  localparam int SA_N         = 4;
  localparam int SA_DATAWIDTH = 8;
  localparam int SA_DRAIN_MAX = 16;
  localparam int SA_ADDR_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Flat index of a 4x4 tile element, row-major (row*4+col).
  function automatic logic [SA_ADDR_W-1:0] sa_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// rtl/systolic_array_ctrl_if.sv - host-side and array-side interfaces of the sequencer
// Purpose: sa_host_if bundles operand writes, job control and result reads;
//          sa_array_if bundles the enumerated ports of one 4x4 Systolic_Array.
// Ports:   sa_host_if  master = host/DMA, slave = controller.
//          sa_array_if master = controller, slave = array.
interface sa_host_if import sa_ctrl_pkg::*; #(
  parameter int DATAWIDTH = SA_DATAWIDTH
) ();
  logic                   wr_en;
  logic                   wr_sel;
  logic [SA_ADDR_W-1:0]   wr_addr;
  logic [DATAWIDTH-1:0]   wr_data;
  logic                   go;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [SA_ADDR_W-1:0]   rd_addr;
  logic [2*DATAWIDTH-1:0] rd_data;

  modport master (output wr_en, wr_sel, wr_addr, wr_data, go, rd_addr,
                  input  busy, done, err, rd_data);
  modport slave  (input  wr_en, wr_sel, wr_addr, wr_data, go, rd_addr,
                  output busy, done, err, rd_data);
endinterface

interface sa_array_if import sa_ctrl_pkg::*; #(
  parameter int DATAWIDTH = SA_DATAWIDTH
) ();
  logic                   sa_RSTn;
  logic                   sa_start;
  logic [DATAWIDTH-1:0]   sa_A0, sa_A1, sa_A2, sa_A3;
  logic [DATAWIDTH-1:0]   sa_B0, sa_B1, sa_B2, sa_B3;
  logic [2*DATAWIDTH-1:0] sa_P11, sa_P12, sa_P13, sa_P14;
  logic [2*DATAWIDTH-1:0] sa_P21, sa_P22, sa_P23, sa_P24;
  logic [2*DATAWIDTH-1:0] sa_P31, sa_P32, sa_P33, sa_P34;
  logic [2*DATAWIDTH-1:0] sa_P41, sa_P42, sa_P43, sa_P44;
  logic                   sa_done;

  modport master (output sa_RSTn, sa_start, sa_A0, sa_A1, sa_A2, sa_A3,
                         sa_B0, sa_B1, sa_B2, sa_B3,
                  input  sa_P11, sa_P12, sa_P13, sa_P14, sa_P21, sa_P22, sa_P23, sa_P24,
                         sa_P31, sa_P32, sa_P33, sa_P34, sa_P41, sa_P42, sa_P43, sa_P44,
                         sa_done);
  modport slave  (input  sa_RSTn, sa_start, sa_A0, sa_A1, sa_A2, sa_A3,
                         sa_B0, sa_B1, sa_B2, sa_B3,
                  output sa_P11, sa_P12, sa_P13, sa_P14, sa_P21, sa_P22, sa_P23, sa_P24,
                         sa_P31, sa_P32, sa_P33, sa_P34, sa_P41, sa_P42, sa_P43, sa_P44,
                         sa_done);
endinterface

// File: rtl/sa_operand_buffer.sv
// rtl/sa_operand_buffer.sv - A and B operand tiles with host write and column/row read
// Purpose: two 16-entry register files. The read port returns column k of A
//          and row k of B for the feed index k.
// Ports:   CLK, RSTn (sync, active-low, clears both tiles);
//          wr_en_i/wr_sel_i/wr_addr_i/wr_data_i host write (sel 0 = A, 1 = B);
//          rd_k_i feed index; a_col_o[i] = A[i][k]; b_row_o[j] = B[k][j].
module sa_operand_buffer import sa_ctrl_pkg::*; #(
  parameter int DATAWIDTH = SA_DATAWIDTH
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 wr_en_i,
  input  logic                 wr_sel_i,
  input  logic [SA_ADDR_W-1:0] wr_addr_i,
  input  logic [DATAWIDTH-1:0] wr_data_i,
  input  logic [1:0]           rd_k_i,
  output logic [DATAWIDTH-1:0] a_col_o [4],
  output logic [DATAWIDTH-1:0] b_row_o [4]
);

  logic [DATAWIDTH-1:0] mem_a_q [16];
  logic [DATAWIDTH-1:0] mem_b_q [16];

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      mem_a_q <= '{default: '0};
      mem_b_q <= '{default: '0};
    end else if (wr_en_i) begin
      if (wr_sel_i) mem_b_q[wr_addr_i] <= wr_data_i;
      else          mem_a_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_col_o[i] = mem_a_q[sa_idx(2'(i), rd_k_i)];
      b_row_o[i] = mem_b_q[sa_idx(rd_k_i, 2'(i))];
    end
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - job sequencer for one 4x4 Systolic_Array
// Purpose: clear the array, stream unskewed A columns / B rows for N cycles,
//          wait for the array's done (bounded by DRAIN_MAX), capture all 16
//          products into a result bank and pulse done.
// Ports:   CLK, RSTn (sync, active-low);
//          host (sa_host_if.slave): operand writes, go, busy/done/err, result read;
//          sa   (sa_array_if.master): array reset/start, operands, products, done.
module systolic_array_ctrl import sa_ctrl_pkg::*; #(
  parameter int DATAWIDTH = SA_DATAWIDTH,
  parameter int N         = SA_N,
  parameter int DRAIN_MAX = SA_DRAIN_MAX
) (
  input  logic       CLK,
  input  logic       RSTn,
  sa_host_if.slave   host,
  sa_array_if.master sa
);

  localparam int CW = $clog2(DRAIN_MAX + 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                   sa_rstn_q, sa_rstn_d, start_q, start_d;
  logic [DATAWIDTH-1:0]   a_q [4], a_d [4], b_q [4], b_d [4];
  logic [DATAWIDTH-1:0]   a_col [4], b_row [4];
  logic [2*DATAWIDTH-1:0] bank_q [16];
  logic [2*DATAWIDTH-1:0] p_w [16];
  logic                   feed_last, drain_timeout;

  // Writes are only honoured while idle; busy_q is the registered busy output.
  sa_operand_buffer #(.DATAWIDTH(DATAWIDTH)) u_buf (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .wr_en_i   (host.wr_en && !busy_q),
    .wr_sel_i  (host.wr_sel),
    .wr_addr_i (host.wr_addr),
    .wr_data_i (host.wr_data),
    .rd_k_i    (cnt_d[1:0]),
    .a_col_o   (a_col),
    .b_row_o   (b_row)
  );

  assign p_w = '{sa.sa_P11, sa.sa_P12, sa.sa_P13, sa.sa_P14,
                 sa.sa_P21, sa.sa_P22, sa.sa_P23, sa.sa_P24,
                 sa.sa_P31, sa.sa_P32, sa.sa_P33, sa.sa_P34,
                 sa.sa_P41, sa.sa_P42, sa.sa_P43, sa.sa_P44};

  // One counter serves as feed index in FEED and drain count in DRAIN.
  assign feed_last     = (cnt_q == CW'(N - 1));
  assign drain_timeout = (cnt_q == CW'(DRAIN_MAX - 1));

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sa_rstn_q <= 1'b0;
      start_q   <= 1'b0;
      a_q       <= '{default: '0};
      b_q       <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sa_rstn_q <= sa_rstn_d;
      start_q   <= start_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE:  if (host.go) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FEED;
      ST_FEED: begin
        if (feed_last) state_d = ST_DRAIN;
        else           cnt_d   = cnt_q + 1'b1;
      end
      ST_DRAIN: begin
        if (sa.sa_done)         state_d = ST_DONE;
        else if (drain_timeout) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    start_d   = (state_d == ST_FEED) || (state_d == ST_DRAIN);
    sa_rstn_d = (state_d != ST_CLEAR);
    err_d     = err_q;
    if (state_q == ST_IDLE && host.go) err_d = 1'b0;
    if (state_q == ST_DRAIN && !sa.sa_done && drain_timeout) err_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_d[i] = (state_d == ST_FEED) ? a_col[i] : '0;
      b_d[i] = (state_d == ST_FEED) ? b_row[i] : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn)                                 bank_q <= '{default: '0};
    else if (state_q == ST_DRAIN && sa.sa_done) bank_q <= p_w;
  end

  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.err     = err_q;
  assign host.rd_data = bank_q[host.rd_addr];

  assign sa.sa_RSTn  = sa_rstn_q;
  assign sa.sa_start = start_q;
  assign sa.sa_A0 = a_q[0];
  assign sa.sa_A1 = a_q[1];
  assign sa.sa_A2 = a_q[2];
  assign sa.sa_A3 = a_q[3];
  assign sa.sa_B0 = b_q[0];
  assign sa.sa_B1 = b_q[1];
  assign sa.sa_B2 = b_q[2];
  assign sa.sa_B3 = b_q[3];

endmodule

// File: doc/systolic_array_ctrl.md
# systolic_array_ctrl

Sequencer for the 4x4 Systolic_Array matrix-multiply datapath. It buffers one 4x4 A tile and one 4x4 B tile written by a host. On `go` it clears the array, streams one A column and one B row per cycle into the array's A0..A3/B0..B3 ports, and waits for the array's Done. It then captures all 16 products into a result bank the host reads back. It sits between the host/DMA side and one Systolic_Array instance.

## Interface
- `DATAWIDTH`, 8: operand width; products are 2*DATAWIDTH.
- `N`, 4: array dimension. Fixed at 4 because the array ports are enumerated.
- `DRAIN_MAX`, 16: maximum cycles spent in DRAIN waiting for `sa_done` before timeout.
- `CLK` in 1: clock, rising edge.
- `RSTn` in 1: reset, synchronous, active-low.
- `wr_en` in 1: operand write strobe. Honoured only while `busy`=0.
- `wr_sel` in 1: 0 writes A, 1 writes B.
- `wr_addr` in 4: operand index, row*4+col.
- `wr_data` in DATAWIDTH: operand value.
- `go` in 1: start request. Sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when results are captured.
- `err` out 1: sticky timeout flag. Cleared by the next accepted `go`.
- `rd_addr` in 4: result index, row*4+col (row 0 is P11..P14).
- `rd_data` out 2*DATAWIDTH: captured result, combinational mux on `rd_addr`.
- `sa_RSTn` out 1: drives the array's RSTn.
- `sa_start` out 1: drives the array's start.
- `sa_A0`..`sa_A3` out DATAWIDTH each: array A inputs.
- `sa_B0`..`sa_B3` out DATAWIDTH each: array B inputs.
- `sa_P11`..`sa_P44` in 2*DATAWIDTH each: array products.
- `sa_done` in 1: array Done.

## Operation
- States and transitions:
  - IDLE -> CLEAR on `go`.
  - CLEAR -> FEED after 1 cycle.
  - FEED -> DRAIN after N cycles.
  - DRAIN -> DONE when `sa_done`=1.
  - DRAIN -> IDLE on timeout.
  - DONE -> IDLE after 1 cycle.
- CLEAR: `sa_RSTn`=0 for exactly one cycle; `sa_start`=0; operands 0.
- FEED cycle k (k=0..3):
  - `sa_Ai` = A[i][k] and `sa_Bj` = B[k][j], i.e. unskewed column k of A and row k of B. The array skews internally.
  - `sa_start`=1.
- DRAIN:
  - Operands 0, `sa_start`=1.
  - Drain counter increments each cycle.
  - If the counter reaches DRAIN_MAX with `sa_done` never sampled high: set `err`, go to IDLE, leave the result bank unchanged, no `done` pulse.
- Capture: on the edge where DRAIN samples `sa_done`=1, load all 16 `sa_P` values into the result bank. DONE then pulses `done`.
- `go` in any state other than IDLE is ignored. `wr_en` while `busy`=1 is ignored.
- `wr_en` and `go` on the same IDLE cycle: the write commits, and the job uses the new value.
- No arithmetic is done in the controller. Products pass through at full 2*DATAWIDTH width.

## Timing
- All outputs are registered except `rd_data`.
- `go` sampled at edge 0 gives:
  - CLEAR in cycle 1;
  - FEED in cycles 2..5;
  - DRAIN from cycle 6.
- `done` is high in the cycle after `sa_done` is sampled. `rd_data` shows the new results from that same cycle.
- Minimum IDLE-to-IDLE time: 1+N+1+1 = 7 cycles after the `go` edge.
- Values while `RSTn`=0 (at the sampling edge):
  - state IDLE;
  - `busy`=0, `done`=0, `err`=0, `sa_start`=0;
  - `sa_RSTn`=0, going to 1 on the first edge with `RSTn`=1;
  - operands 0;
  - operand buffers and result bank 0.
- Reset asserted mid-job aborts at the next edge with the reset values above. No `done` pulse.

## Structure
- Shared package `sa_ctrl_pkg` holds:
  - the state encoding (IDLE, CLEAR, FEED, DRAIN, DONE);
  - the N, DATAWIDTH and DRAIN_MAX defaults;
  - the address width of 4;
  - the index helper row*4+col.
- One natural sub-module, `sa_operand_buffer`: a 2x16xDATAWIDTH register file with a host write port and a column/row read port selected by the feed counter.
- FSM, feed/drain counters, result bank and read mux stay in the top module.

## Test plan
- Directed job, bench array model computes A*B:
  - Stimulus: A rows {1,2,3,4},{6,7,8,9},{11,12,13,14},{16,17,18,19}; B = identity; `go`.
  - Required: FEED cycle 0 shows `sa_A0..3`=1,6,11,16 and `sa_B0..3`=1,0,0,0. Cycle 3 shows `sa_A0..3`=4,9,14,19 and `sa_B3`=1.
  - Required: one `done` pulse; `rd_addr`=5 reads 7; `rd_addr`=15 reads 19.
- Sequencing check:
  - Stimulus: same job as above.
  - Required: `sa_RSTn` low exactly cycle 1; `sa_start` high from cycle 2 until DONE; `busy` high cycles 1 through DONE.
- Timeout:
  - Stimulus: model never asserts `sa_done`; DRAIN_MAX=16.
  - Required: after 16 DRAIN cycles `err`=1, `busy`=0, no `done`, previous results unchanged.
  - Required: next `go` clears `err`.
- Ignored requests:
  - Stimulus: write A[0][0]=99 and pulse `go` during FEED.
  - Required: job completes once. Next job's FEED cycle 0 has `sa_A0`=1.
  - Stimulus: `go` in the DONE cycle.
  - Required: ignored. `go` one cycle later is accepted.
- Reset mid-FEED:
  - Stimulus: `RSTn`=0 at FEED cycle 2.
  - Required: next edge gives `busy`=0, `sa_start`=0, `sa_RSTn`=0; all `rd_data`=0; a subsequent job with unwritten buffers yields all-zero results.
